fifo_stream_adapter: RTL and testbench

// - Sits directly downstream of RawFIFO. Converts its fixed-read-latency pop interface (may_pop/pop/pop_data) into a

---
 rtl/fifo_stream_adapter.sv | 110 +++++++++++
 tb/tb_fifo_stream_adapter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_adapter.sv
// fifo_stream_adapter: fixed read-latency FIFO pop port -> valid/ready stream.
// Ports: clk, rst_n (async low); fifo_may_pop/fifo_pop/fifo_data (upstream);
//   out_valid/out_ready/out_data (downstream); words_out (32-bit delivered
//   count) exists only when FIFO_STREAM_ADAPTER_STATS_EN is defined.
module fifo_stream_adapter #(
    parameter int WIDTH        = 8,
    parameter int READ_LATENCY = 2,
    parameter int SKID_DEPTH   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_may_pop,
    output logic             fifo_pop,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef FIFO_STREAM_ADAPTER_STATS_EN
    ,
    output logic [31:0]      words_out
`endif
);
    localparam int CW = $clog2(SKID_DEPTH + 1);
    localparam int PW = $clog2(SKID_DEPTH);
    localparam int SW = CW + 1;
    localparam logic [PW-1:0] LAST = PW'(SKID_DEPTH - 1);

    if (READ_LATENCY < 1) begin : g_bad_lat
        $error("READ_LATENCY must be at least 1");
    end
    if (SKID_DEPTH < READ_LATENCY + 1) begin : g_bad_depth
        $error("SKID_DEPTH must be at least READ_LATENCY+1");
    end

    logic [READ_LATENCY-1:0] r_pipe;
    logic [WIDTH-1:0]        r_mem [SKID_DEPTH];
    logic [PW-1:0]           r_wr_ptr;
    logic [PW-1:0]           r_rd_ptr;
    logic [CW-1:0]           r_count;
    logic [CW-1:0]           w_inflight;
    logic                    w_capture;
    logic                    w_xfer;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            w_inflight = w_inflight + CW'(r_pipe[i]);
        end
    end

    // Credit counts words already requested, so every returning word
    // is guaranteed a slot; out_ready never feeds this path.
    assign fifo_pop  = fifo_may_pop &&
                       (({1'b0, w_inflight} + {1'b0, r_count})
                        < SW'(SKID_DEPTH));
    assign w_capture = r_pipe[READ_LATENCY-1];
    assign out_valid = (r_count != '0);
    assign w_xfer    = out_valid && out_ready;
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= fifo_pop;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_capture) begin
                r_mem[r_wr_ptr] <= fifo_data;
                r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_xfer) begin
                r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_capture && !w_xfer) begin
                r_count <= r_count + 1'b1;
            end else if (!w_capture && w_xfer) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

`ifdef FIFO_STREAM_ADAPTER_STATS_EN
    logic [31:0] r_words_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_words_out <= '0;
        end else if (w_xfer) begin
            r_words_out <= r_words_out + 32'd1;
        end
    end

    assign words_out = r_words_out;
`endif

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// tb_fifo_stream_adapter: scoreboard bench for fifo_stream_adapter.
// DUT a uses defaults; DUT b uses SKID_DEPTH=5, READ_LATENCY=1.
module tb_fifo_stream_adapter;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic         a_en = 1'b0;
    int           a_src_cnt = 0;
    logic         a_may_pop, a_pop, a_valid;
    logic         a_ready = 1'b0;
    logic [W-1:0] a_fdata, a_data;
    logic [W-1:0] a_dl0 = 8'hEE, a_dl1 = 8'hEE;
    logic         a_dv0 = 1'b0, a_dv1 = 1'b0;
    int           a_cnt = 0;
    int           a_nx = 0;
    bit           a_xfer_n = 1'b0, a_pop_n = 1'b0;
    logic [W-1:0] a_src [$];
    logic [W-1:0] a_exp [$];

    logic         b_en = 1'b0;
    logic         b_pop, b_valid;
    logic         b_ready = 1'b0;
    logic [W-1:0] b_fdata = 8'hEE, b_data;
    logic         b_dv = 1'b0;
    logic [W-1:0] b_seq = 8'h00;
    int           b_cnt = 0;
    int           b_nx = 0;
    bit           b_xfer_n = 1'b0, b_pop_n = 1'b0;
    logic [W-1:0] b_exp [$];

`ifdef FIFO_STREAM_ADAPTER_STATS_EN
    logic [31:0]  a_words, b_words;
`endif

    assign a_may_pop = a_en && (a_src_cnt != 0);
    assign a_fdata   = a_dl1;

    fifo_stream_adapter dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_may_pop (a_may_pop),
        .fifo_pop     (a_pop),
        .fifo_data    (a_fdata),
        .out_valid    (a_valid),
        .out_ready    (a_ready),
        .out_data     (a_data)
`ifdef FIFO_STREAM_ADAPTER_STATS_EN
        ,
        .words_out    (a_words)
`endif
    );

    fifo_stream_adapter #(
        .WIDTH        (W),
        .READ_LATENCY (1),
        .SKID_DEPTH   (5)
    ) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_may_pop (b_en),
        .fifo_pop     (b_pop),
        .fifo_data    (b_fdata),
        .out_valid    (b_valid),
        .out_ready    (b_ready),
        .out_data     (b_data)
`ifdef FIFO_STREAM_ADAPTER_STATS_EN
        ,
        .words_out    (b_words)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Upstream FIFO model for dut a: pops at the edge, data READ_LATENCY
    // edges later. Also tracks how many words the adapter should hold.
    initial forever begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            a_cnt = 0;
            a_dv0 = 1'b0;
            a_dv1 = 1'b0;
        end else begin
            if (a_dv1) begin
                chk("a_overflow", 32'(a_cnt == 4 && !a_xfer_n), 0);
            end
            a_cnt = a_cnt + int'(a_dv1) - int'(a_xfer_n);
            a_dl1 = a_dl0;
            a_dv1 = a_dv0;
            a_dv0 = a_pop_n;
            a_dl0 = 8'hEE;
            if (a_pop_n) begin
                if (a_src.size() == 0) begin
                    chk("a_pop_empty", 1, 0);
                end else begin
                    a_dl0 = a_src.pop_front();
                end
            end
            a_src_cnt = a_src.size();
        end
        a_xfer_n = 1'b0;
        a_pop_n  = 1'b0;
    end

    initial forever begin
        @(negedge clk);
        chk("a_valid", 32'(a_valid), 32'(a_cnt != 0));
        chk("a_count_max", 32'(a_cnt <= 4), 1);
        chk("a_pop", 32'(a_pop), 32'(a_may_pop &&
            (a_cnt + int'(a_dv0) + int'(a_dv1) < 4)));
        if (!a_valid) chk("a_data_idle", 32'(a_data), 0);
        a_pop_n = a_pop;
        if (a_valid && a_ready) begin
            a_xfer_n = 1'b1;
            a_nx++;
            if (a_exp.size() == 0) begin
                chk("a_unexpected", 32'(a_data), 32'hFFFF_FFFF);
            end else begin
                chk("a_data", 32'(a_data), 32'(a_exp.pop_front()));
            end
        end
    end

    // Endless source for dut b; expected word pushed when popped.
    initial forever begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            b_cnt = 0;
            b_dv  = 1'b0;
        end else begin
            if (b_dv) begin
                chk("b_overflow", 32'(b_cnt == 5 && !b_xfer_n), 0);
            end
            b_cnt = b_cnt + int'(b_dv) - int'(b_xfer_n);
            b_dv = b_pop_n;
            b_fdata = 8'hEE;
            if (b_pop_n) begin
                b_fdata = b_seq;
                b_exp.push_back(b_seq);
                b_seq = b_seq + 8'd1;
            end
        end
        b_xfer_n = 1'b0;
        b_pop_n  = 1'b0;
    end

    initial forever begin
        @(negedge clk);
        chk("b_valid", 32'(b_valid), 32'(b_cnt != 0));
        chk("b_pop", 32'(b_pop), 32'(b_en && (b_cnt + int'(b_dv) < 5)));
        b_pop_n = b_pop;
        if (b_valid && b_ready) begin
            b_xfer_n = 1'b1;
            b_nx++;
            if (b_exp.size() == 0) begin
                chk("b_unexpected", 32'(b_data), 32'hFFFF_FFFF);
            end else begin
                chk("b_data", 32'(b_data), 32'(b_exp.pop_front()));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic load(input logic [W-1:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            a_src.push_back(first + W'(i));
            a_exp.push_back(first + W'(i));
        end
        a_src_cnt = a_src.size();
    endtask

    task automatic drain(input string nm);
        int t = 0;
        while (a_exp.size() != 0 && t < 300) begin
            cyc(1);
            t++;
        end
        chk(nm, 32'(a_exp.size()), 0);
    endtask

    task automatic clear_a();
        a_en = 1'b0;
        a_src.delete();
        a_exp.delete();
        a_src_cnt = 0;
        a_cnt = 0;
        a_dv0 = 1'b0;
        a_dv1 = 1'b0;
        a_dl0 = 8'hEE;
        a_dl1 = 8'hEE;
        a_xfer_n = 1'b0;
        a_pop_n = 1'b0;
    endtask

    initial begin
        logic [W-1:0] seq;
        int t;
        #1;
        chk("rst_valid", 32'(a_valid), 0);
        chk("rst_pop", 32'(a_pop), 0);
        chk("rst_data", 32'(a_data), 0);
        cyc(3);
        rst_n = 1'b1;
        cyc(2);

        // Streaming at full rate.
        load(8'h01, 16);
        a_ready = 1'b1;
        a_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("t1_valid_%0d", i), 32'(a_valid),
                32'(i >= 3 && i < 19));
        end
        cyc(1);
        chk("t1_done", 32'(a_exp.size()), 0);

        // Backpressure.
        a_ready = 1'b0;
        load(8'h20, 8);
        cyc(8);
        chk("t2_buffered", 32'(a_cnt), 4);
        chk("t2_src_left", 32'(a_src_cnt), 4);
        chk("t2_pop_off", 32'(a_pop), 0);
        repeat (5) begin
            @(negedge clk);
            chk("t2_stall_data", 32'(a_data), 32'h20);
        end
        cyc(1);
        a_ready = 1'b1;
        drain("t2_drain");

        // Underrun and resume.
        load(8'h30, 3);
        cyc(10);
        chk("t3_valid_low", 32'(a_valid), 0);
        chk("t3_pop_low", 32'(a_pop), 0);
        load(8'h33, 3);
        drain("t3_drain");

        // Random ready and may_pop.
        seq = 8'h00;
        t = 0;
        a_nx = 0;
        while (a_nx < 10000 && t < 60000) begin
            a_ready = 1'($urandom_range(0, 1));
            a_en = ($urandom_range(0, 3) != 0);
            while (a_src.size() < 6) begin
                a_src.push_back(seq);
                a_exp.push_back(seq);
                seq = seq + 8'd1;
            end
            a_src_cnt = a_src.size();
            cyc(1);
            t++;
        end
        chk("t4_words", 32'(a_nx >= 10000), 1);
        a_en = 1'b1;
        a_ready = 1'b1;
        drain("t4_drain");

        // Reset with words buffered and in flight.
        load(8'h40, 20);
        cyc(4);
        a_ready = 1'b0;
        cyc(1);
        chk("t5_pre_inflight", 32'(a_dv0 || a_dv1), 1);
        chk("t5_pre_buffered", 32'(a_cnt != 0), 1);
        rst_n = 1'b0;
        clear_a();
        #1;
        chk("t5_valid_async", 32'(a_valid), 0);
        chk("t5_pop_async", 32'(a_pop), 0);
        chk("t5_data_async", 32'(a_data), 0);
        cyc(2);
        rst_n = 1'b1;
        load(8'h50, 6);
        a_en = 1'b1;
        a_ready = 1'b1;
        drain("t5_drain");

        // Second configuration: depth 5, latency 1.
        b_nx = 0;
        b_en = 1'b1;
        t = 0;
        while (b_nx < 300 && t < 5000) begin
            b_ready = 1'($urandom_range(0, 1));
            cyc(1);
            t++;
        end
        b_ready = 1'b0;
        chk("b_words_seen", 32'(b_nx), 300);
        cyc(6);
        b_en = 1'b0;
        cyc(2);
        chk("b_full", 32'(b_cnt), 5);
`ifdef FIFO_STREAM_ADAPTER_STATS_EN
        chk("b_words_out", b_words, 300);
        force dut_b.r_words_out = 32'hFFFF_FFFF;
        #1;
        release dut_b.r_words_out;
        b_ready = 1'b1;
        cyc(1);
        b_ready = 1'b0;
        @(negedge clk);
        chk("b_words_wrap", b_words, 0);
`endif
        cyc(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
